// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode constants, sequencer state encoding and opcode-class
// helpers for the 8-bit CPU instruction sequencer.
package cpu_pkg;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;
    localparam logic [7:0] OP_J     = 8'd6;
    localparam logic [7:0] OP_BEQ   = 8'd7;
    localparam logic [7:0] OP_LWD   = 8'd8;
    localparam logic [7:0] OP_LWI   = 8'd9;
    localparam logic [7:0] OP_SWD   = 8'd10;
    localparam logic [7:0] OP_SWI   = 8'd11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } seq_state_e;

    // Single-cycle register-writing ops (loadi .. or)
    function automatic logic is_alu_op(input logic [7:0] op);
        return op <= OP_OR;
    endfunction

    function automatic logic is_branch_op(input logic [7:0] op);
        return (op == OP_J) || (op == OP_BEQ);
    endfunction

    function automatic logic is_mem_op(input logic [7:0] op);
        return (op >= OP_LWD) && (op <= OP_SWI);
    endfunction

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == OP_LWD) || (op == OP_LWI);
    endfunction

endpackage

// File: rtl/seq_next_pc.sv
// seq_next_pc: combinational next-PC generator.
//   pc_i       current PC
//   offset_i   signed 8-bit word offset from INSTRUCTION[23:16]
//   take_i     1 selects the branch target, 0 selects PC+4
//   next_pc_o  selected next PC (modulo 2^PC_W)
// PC_W must be at least 10 so the shifted offset fits.
module seq_next_pc #(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [7:0]      offset_i,
    input  logic            take_i,
    output logic [PC_W-1:0] next_pc_o
);

    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] branch_off;

    assign pc_plus4   = pc_i + PC_W'(4);
    // Sign-extend the word offset and convert to a byte offset
    assign branch_off = {{(PC_W-10){offset_i[7]}}, offset_i, 2'b00};
    assign next_pc_o  = take_i ? (pc_plus4 + branch_off) : pc_plus4;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch / execute / data-memory sequencer for the
// 8-bit CPU. Owns the PC, latches the instruction word and generates memory
// requests plus the register-file write and retire strobes.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   INSTR_READDATA        instruction memory read data
//   INSTR_BUSYWAIT        instruction memory stall (honoured in S_FETCH only)
//   MEM_BUSYWAIT          data memory stall (honoured in S_MEM only)
//   ZERO                  ALU zero flag, used by beq in S_EXEC
//   INSTR_READ            fetch request (registered)
//   PC                    current PC
//   INSTRUCTION           latched instruction word
//   MEM_READ / MEM_WRITE  data memory requests (registered, mutually exclusive)
//   REG_WRITE, RETIRE     one-cycle strobes
//   ILLEGAL               sticky undefined-opcode flag
//   RETIRED_CNT, STALL_CNT performance counters
// Build option: define SEQ_PERF_CNT_EN to implement the performance counters;
// when undefined both counter outputs are tied to zero.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter bit              ILLEGAL_HALT = 1'b0
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [31:0]     INSTR_READDATA,
    input  logic            INSTR_BUSYWAIT,
    input  logic            MEM_BUSYWAIT,
    input  logic            ZERO,
    output logic            INSTR_READ,
    output logic [PC_W-1:0] PC,
    output logic [31:0]     INSTRUCTION,
    output logic            MEM_READ,
    output logic            MEM_WRITE,
    output logic            REG_WRITE,
    output logic            RETIRE,
    output logic            ILLEGAL,
    output logic [31:0]     RETIRED_CNT,
    output logic [31:0]     STALL_CNT
);

    seq_state_e      state_q;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            illegal_q;
    logic            instr_read_q;
    logic            mem_read_q;
    logic            mem_write_q;

    logic [7:0]      opcode;
    logic            take_branch;
    logic [PC_W-1:0] pc_next;
    logic            reg_write_c;
    logic            retire_c;

    assign opcode      = instr_q[31:24];
    assign take_branch = (opcode == OP_J) || ((opcode == OP_BEQ) && ZERO);

    seq_next_pc #(.PC_W(PC_W)) u_next_pc (
        .pc_i      (pc_q),
        .offset_i  (instr_q[23:16]),
        .take_i    (take_branch),
        .next_pc_o (pc_next)
    );

    // Control FSM; the request outputs are registered alongside the state
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            illegal_q    <= 1'b0;
            instr_read_q <= 1'b1;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (!INSTR_BUSYWAIT) begin
                        instr_q      <= INSTR_READDATA;
                        instr_read_q <= 1'b0;
                        state_q      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_mem_op(opcode)) begin
                        mem_read_q  <= is_load_op(opcode);
                        mem_write_q <= ~is_load_op(opcode);
                        state_q     <= S_MEM;
                    end else if (!is_alu_op(opcode) && !is_branch_op(opcode) && ILLEGAL_HALT) begin
                        illegal_q <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        if (!is_alu_op(opcode) && !is_branch_op(opcode)) begin
                            illegal_q <= 1'b1;
                        end
                        pc_q         <= pc_next;
                        instr_read_q <= 1'b1;
                        state_q      <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (!MEM_BUSYWAIT) begin
                        pc_q         <= pc_next;
                        mem_read_q   <= 1'b0;
                        mem_write_q  <= 1'b0;
                        instr_read_q <= 1'b1;
                        state_q      <= S_FETCH;
                    end
                end
                default: begin
                    // S_HALT: frozen until reset
                end
            endcase
        end
    end

    // Strobes must react to MEM_BUSYWAIT in the same cycle, so they are decoded
    // from the registered state rather than registered themselves.
    always_comb begin
        reg_write_c = 1'b0;
        retire_c    = 1'b0;
        case (state_q)
            S_EXEC: begin
                if (is_alu_op(opcode)) begin
                    reg_write_c = 1'b1;
                    retire_c    = 1'b1;
                end else if (is_branch_op(opcode)) begin
                    retire_c = 1'b1;
                end else if (!is_mem_op(opcode) && !ILLEGAL_HALT) begin
                    retire_c = 1'b1;
                end
            end
            S_MEM: begin
                if (!MEM_BUSYWAIT) begin
                    reg_write_c = is_load_op(opcode);
                    retire_c    = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Reset overrides any strobe that would otherwise fire in the reset cycle
    assign REG_WRITE   = reg_write_c & ~RESET;
    assign RETIRE      = retire_c & ~RESET;
    assign INSTR_READ  = instr_read_q;
    assign MEM_READ    = mem_read_q;
    assign MEM_WRITE   = mem_write_q;
    assign PC          = pc_q;
    assign INSTRUCTION = instr_q;
    assign ILLEGAL     = illegal_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        stall_c;

    assign stall_c = ((state_q == S_FETCH) && INSTR_BUSYWAIT) ||
                     ((state_q == S_MEM) && MEM_BUSYWAIT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            retired_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            if (retire_c) begin
                retired_cnt_q <= retired_cnt_q + 32'd1;
            end
            if (stall_c) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign RETIRED_CNT = retired_cnt_q;
    assign STALL_CNT   = stall_cnt_q;
`else
    assign RETIRED_CNT = '0;
    assign STALL_CNT   = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

`ifdef SEQ_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    localparam logic [31:0] W_ADD = 32'h02_01_02_03;
    localparam logic [31:0] W_SUB = 32'h03_02_01_00;
    localparam logic [31:0] W_OR  = 32'h05_03_01_02;
    localparam logic [31:0] W_AND = 32'h04_01_02_03;
    localparam logic [31:0] W_MOV = 32'h01_02_00_03;
    localparam logic [31:0] W_BEQ = 32'h07_02_01_02;
    localparam logic [31:0] W_J   = 32'h06_FF_00_00;
    localparam logic [31:0] W_LWD = 32'h08_01_00_02;
    localparam logic [31:0] W_SWD = 32'h0A_00_01_02;
    localparam logic [31:0] W_ILL = 32'h3F_00_00_00;

    logic        clk = 1'b0;
    logic        rst, ibusy, mbusy, zero;
    logic [31:0] rdata;

    logic        ird, mrd, mwr, rw, ret, ill;
    logic [31:0] pc, instr, rcnt, scnt;
    logic        h_ird, h_mrd, h_mwr, h_rw, h_ret, h_ill;
    logic [31:0] h_pc, h_instr, h_rcnt, h_scnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .CLK(clk), .RESET(rst), .INSTR_READDATA(rdata), .INSTR_BUSYWAIT(ibusy),
        .MEM_BUSYWAIT(mbusy), .ZERO(zero), .INSTR_READ(ird), .PC(pc),
        .INSTRUCTION(instr), .MEM_READ(mrd), .MEM_WRITE(mwr), .REG_WRITE(rw),
        .RETIRE(ret), .ILLEGAL(ill), .RETIRED_CNT(rcnt), .STALL_CNT(scnt)
    );

    cpu_sequencer #(.ILLEGAL_HALT(1'b1)) dut_h (
        .CLK(clk), .RESET(rst), .INSTR_READDATA(rdata), .INSTR_BUSYWAIT(ibusy),
        .MEM_BUSYWAIT(mbusy), .ZERO(zero), .INSTR_READ(h_ird), .PC(h_pc),
        .INSTRUCTION(h_instr), .MEM_READ(h_mrd), .MEM_WRITE(h_mwr), .REG_WRITE(h_rw),
        .RETIRE(h_ret), .ILLEGAL(h_ill), .RETIRED_CNT(h_rcnt), .STALL_CNT(h_scnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %-18s got %08h expected %08h", tag, got, exp);
        end else begin
            $display("  ok %-18s = %08h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Fetch + execute of a register-writing op at pc_now (zero-wait fetch)
    task automatic run_alu(input logic [31:0] word, input logic [31:0] pc_now);
        rdata = word;
        ibusy = 1'b0;
        #1;
        check("alu fetch pc", pc, pc_now);
        check("alu fetch ird", {31'd0, ird}, 32'd1);
        check("alu fetch rw", {31'd0, rw}, 32'd0);
        next_cycle();
        #1;
        check("alu instr", instr, word);
        check("alu exec rw", {31'd0, rw}, 32'd1);
        check("alu exec retire", {31'd0, ret}, 32'd1);
        next_cycle();
        #1;
        check("alu next pc", pc, pc_now + 32'd4);
    endtask

    task automatic run_branch(input logic [31:0] word, input logic z,
                              input logic [31:0] pc_now, input logic [31:0] pc_exp);
        rdata = word;
        #1;
        check("br fetch pc", pc, pc_now);
        next_cycle();
        zero = z;
        #1;
        check("br exec retire", {31'd0, ret}, 32'd1);
        check("br exec rw", {31'd0, rw}, 32'd0);
        next_cycle();
        zero = 1'b0;
        #1;
        check("br target pc", pc, pc_exp);
    endtask

    initial begin
        rst = 1'b1; ibusy = 1'b0; mbusy = 1'b0; zero = 1'b0; rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        // Reset state
        check("rst pc", pc, 32'h0);
        check("rst instr", instr, 32'h0);
        check("rst ird", {31'd0, ird}, 32'd1);
        check("rst mrd", {31'd0, mrd}, 32'd0);
        check("rst mwr", {31'd0, mwr}, 32'd0);
        check("rst illegal", {31'd0, ill}, 32'd0);
        check("rst rcnt", rcnt, 32'd0);
        check("rst scnt", scnt, 32'd0);

        // 1: zero-wait ALU stream
        run_alu(W_ADD, 32'h0);
        run_alu(W_SUB, 32'h4);
        run_alu(W_OR,  32'h8);
        check("t1 rcnt", rcnt, PERF_EN ? 32'd3 : 32'd0);

        // 2: fetch stalled 3 cycles, garbage on the bus until release
        ibusy = 1'b1;
        rdata = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2 ird stall", {31'd0, ird}, 32'd1);
            next_cycle();
        end
        ibusy = 1'b0;
        rdata = W_AND;
        #1;
        check("t2 ird release", {31'd0, ird}, 32'd1);
        check("t2 pc hold", pc, 32'hC);
        next_cycle();
        ibusy = 1'b1;           // must be ignored outside fetch
        #1;
        check("t2 latched", instr, W_AND);
        check("t2 ird exec", {31'd0, ird}, 32'd0);
        check("t2 exec rw", {31'd0, rw}, 32'd1);
        next_cycle();
        ibusy = 1'b0;
        #1;
        check("t2 pc", pc, 32'h10);
        check("t2 scnt", scnt, PERF_EN ? 32'd3 : 32'd0);

        // 3: branches
        run_branch(W_BEQ, 1'b1, 32'h10, 32'h1C);
        run_branch(W_BEQ, 1'b0, 32'h1C, 32'h20);
        run_branch(W_J,   1'b0, 32'h20, 32'h20);

        // 4: load with 5 busy cycles
        rdata = W_LWD;
        #1;
        next_cycle();
        mbusy = 1'b1;           // ignored during execute
        #1;
        check("t4 exec mrd", {31'd0, mrd}, 32'd0);
        check("t4 exec retire", {31'd0, ret}, 32'd0);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4 mrd busy", {31'd0, mrd}, 32'd1);
            check("t4 rw busy", {31'd0, rw}, 32'd0);
            check("t4 mwr busy", {31'd0, mwr}, 32'd0);
            next_cycle();
        end
        mbusy = 1'b0;
        #1;
        check("t4 mrd release", {31'd0, mrd}, 32'd1);
        check("t4 rw release", {31'd0, rw}, 32'd1);
        check("t4 retire", {31'd0, ret}, 32'd1);
        check("t4 pc hold", pc, 32'h20);
        next_cycle();
        #1;
        check("t4 mrd drop", {31'd0, mrd}, 32'd0);
        check("t4 rw after", {31'd0, rw}, 32'd0);
        check("t4 pc", pc, 32'h24);
        check("t4 ird", {31'd0, ird}, 32'd1);
        check("t4 rcnt", rcnt, PERF_EN ? 32'd8 : 32'd0);
        check("t4 scnt", scnt, PERF_EN ? 32'd8 : 32'd0);

        // 5: reset in the middle of a stalled store
        rdata = W_SWD;
        #1;
        next_cycle();
        mbusy = 1'b1;
        #1;
        check("t5 exec mwr", {31'd0, mwr}, 32'd0);
        next_cycle();
        #1;
        check("t5 mwr", {31'd0, mwr}, 32'd1);
        check("t5 mrd", {31'd0, mrd}, 32'd0);
        next_cycle();
        rst = 1'b1;
        #1;
        check("t5 mwr pre-rst", {31'd0, mwr}, 32'd1);
        check("t5 retire in rst", {31'd0, ret}, 32'd0);
        next_cycle();
        rst = 1'b0;
        mbusy = 1'b0;
        #1;
        check("t5 mwr after rst", {31'd0, mwr}, 32'd0);
        check("t5 pc after rst", pc, 32'h0);
        check("t5 instr rst", instr, 32'h0);
        check("t5 ird refetch", {31'd0, ird}, 32'd1);
        check("t5 scnt rst", scnt, 32'd0);
        run_alu(W_MOV, 32'h0);

        // 6: illegal opcode, skip vs halt
        rdata = W_ILL;
        #1;
        next_cycle();
        #1;
        check("t6 retire", {31'd0, ret}, 32'd1);
        check("t6 rw", {31'd0, rw}, 32'd0);
        check("t6 h retire", {31'd0, h_ret}, 32'd0);
        next_cycle();
        #1;
        check("t6 illegal", {31'd0, ill}, 32'd1);
        check("t6 pc", pc, 32'h8);
        check("t6 ird", {31'd0, ird}, 32'd1);
        check("t6 h illegal", {31'd0, h_ill}, 32'd1);
        check("t6 h pc", h_pc, 32'h4);
        check("t6 h ird", {31'd0, h_ird}, 32'd0);
        run_alu(W_AND, 32'h8);
        check("t6 sticky", {31'd0, ill}, 32'd1);
        check("t6 rcnt", rcnt, PERF_EN ? 32'd3 : 32'd0);
        check("t6 h pc frozen", h_pc, 32'h4);
        check("t6 h ird frozen", {31'd0, h_ird}, 32'd0);
        check("t6 h rw", {31'd0, h_rw}, 32'd0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("t6 h pc rst", h_pc, 32'h0);
        check("t6 h ird rst", {31'd0, h_ird}, 32'd1);
        check("t6 h ill rst", {31'd0, h_ill}, 32'd0);
        check("t6 ill rst", {31'd0, ill}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
